cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Consumer end of the ALU result/flag interface.
- Holds the architectural NZCV flag register and updates it from the 4-bit ALUFlags bus {N,Z,C,V}.
- Evaluates the 4-bit ARM condition field of each instruction and gates the datapath write/branch enables.
- Sits between the control decoder and the register file, memory and PC mux; all gated enables leave through one registered stage.

Parameters:
- FLAG_RESET, 4'b0000: value loaded into the flag register {N,Z,C,V} on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Valid  input  1  an instruction is presented this cycle.
- Cond  input  4  instruction condition field.
- ALUFlags  input  4  {N,Z,C,V} from the ALU for this instruction.
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  decoder branch/PC-write request.
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  compare-class instruction; suppresses the register write.
- CondEx  output  1  combinational condition-pass for the current Cond against the flag register.
- Flags  output  4  current flag register {N,Z,C,V}.
- OutValid  output  1  registered Valid.
- PCSrc  output  1  registered, gated PCS.
- RegWrite  output  1  registered, gated RegW.
- MemWrite  output  1  registered, gated MemW.

Behaviour:
- Reset (reset_n low, asynchronous): Flags = FLAG_RESET; OutValid, PCSrc, RegWrite, MemWrite = 0. Hold while low; the first update occurs on the first rising clk edge after release.
- CondEx is combinational from Cond and the flag register contents before this cycle's update, never from ALUFlags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Flag update at a rising edge only when Valid & CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - The halves are independent; FlagW=00 leaves the register unchanged.
- Output stage, registered every rising edge (1-cycle latency):
  - OutValid <= Valid
  - PCSrc <= Valid&CondEx&PCS
  - RegWrite <= Valid&CondEx&RegW&~NoWrite
  - MemWrite <= Valid&CondEx&MemW
- Valid=0: no flag update, and all registered enables go to 0 next cycle regardless of the other inputs.
- Back-to-back instructions: the instruction in cycle k+1 evaluates against flags written at the edge ending cycle k. No bypass of ALUFlags into CondEx.
- A failed condition blocks both the flag update and all enables for that instruction.
- Reset asserted mid-stream: the in-flight instruction is discarded and outputs drop to 0 immediately (asynchronously).
- No X propagation: all outputs are defined for every Cond value, including 1111.

Test Plan:
- Reset: hold reset_n=0 with Valid=1, RegW=1, Cond=1110 -> Flags=0000, all outputs 0; release -> RegWrite=1 one cycle later.
- Flag write: Valid=1, Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 next cycle. Next instruction Cond=0000 RegW=1 -> RegWrite=1; Cond=0001 -> RegWrite=0.
- Partial write: Flags=1111; issue FlagW=10, ALUFlags=0000 -> Flags=0011. Then FlagW=01, ALUFlags=0000 -> Flags=0000.
- Signed conditions, using Cond 1010/1011/1100/1101 with RegW=1:
  - Flags=1001 -> GE, GT pass; LT, LE fail.
  - Flags=1000 -> LT, LE pass.
  - Flags=0100 -> LE pass, GT fail.
- Gating:
  - Cond=1111 with PCS=1, RegW=1, MemW=1, FlagW=11 -> all enables 0 and Flags unchanged.
  - Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, Flags=0110.
- Mid-stream reset: stream of AL MemW=1 instructions, pulse reset_n low between edges -> MemWrite falls immediately, Flags=FLAG_RESET, resumes one cycle after release.

Source files
------------

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition evaluation, NZCV flag register and gated enable stage
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Valid,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       OutValid,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flag_q;
  logic       n_f, z_f, c_f, v_f;
  logic       exec;

  assign n_f   = flag_q[3];
  assign z_f   = flag_q[2];
  assign c_f   = flag_q[1];
  assign v_f   = flag_q[0];
  assign Flags = flag_q;

  // Condition pass looks only at the stored flags, so an instruction never sees its own ALU result.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign exec = Valid & CondEx;

  // Flag register: N,Z and C,V halves load independently, only for executing instructions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= FLAG_RESET;
    end else if (exec) begin
      if (FlagW[1]) flag_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flag_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Single registered stage for all gated enables; reset drops them immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      OutValid <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      OutValid <= Valid;
      PCSrc    <= exec & PCS;
      RegWrite <= exec & RegW & ~NoWrite;
      MemWrite <= exec & MemW;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit with directed vectors
module tb_cond_unit;

  logic       clk;
  logic       reset_n;
  logic       valid;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       cond_ex;
  logic [3:0] flags;
  logic       out_valid;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;

  int errors = 0;
  int checks = 0;

  // expected {PCSrc, RegWrite, MemWrite, Flags} per issued valid instruction
  logic [6:0] exp_q[$];

  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Valid    (valid),
    .Cond     (cond),
    .ALUFlags (alu_flags),
    .FlagW    (flag_w),
    .PCS      (pcs),
    .RegW     (reg_w),
    .MemW     (mem_w),
    .NoWrite  (no_write),
    .CondEx   (cond_ex),
    .Flags    (flags),
    .OutValid (out_valid),
    .PCSrc    (pc_src),
    .RegWrite (reg_write),
    .MemWrite (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // drive one instruction, check the combinational condition, queue the registered result
  task automatic issue(input string name, input logic v, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic p, input logic r, input logic m, input logic nw,
                       input logic ece, input logic [2:0] een, input logic [3:0] efl);
    valid = v; cond = c; alu_flags = alu; flag_w = fw;
    pcs = p; reg_w = r; mem_w = m; no_write = nw;
    #1;
    check({"condex_", name}, {6'd0, cond_ex}, {6'd0, ece});
    if (v) exp_q.push_back({een, efl});
  endtask

  task automatic step(input string name, input logic v, input logic [3:0] c,
                      input logic [3:0] alu, input logic [1:0] fw,
                      input logic p, input logic r, input logic m, input logic nw,
                      input logic ece, input logic [2:0] een, input logic [3:0] efl);
    @(posedge clk); #1;
    issue(name, v, c, alu, fw, p, r, m, nw, ece, een, efl);
  endtask

  // monitor: pop and compare whenever the DUT presents a registered instruction
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_outvalid", 7'd1, 7'd0);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          check("enables_flags", {pc_src, reg_write, mem_write, flags}, e);
        end
      end else begin
        check("idle_enables", {4'd0, pc_src, reg_write, mem_write}, 7'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    valid = 1'b1; cond = 4'b1110; alu_flags = 4'b1111; flag_w = 2'b11;
    pcs = 1'b0; reg_w = 1'b1; mem_w = 1'b0; no_write = 1'b0;

    // reset held with an AL instruction presented
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {3'd0, flags}, 7'd0);
    check("reset_outs", {3'd0, out_valid, pc_src, reg_write, mem_write}, 7'd0);
    #2;
    reset_n = 1'b1;
    issue("rst_release", 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b0000);

    //   name           v  cond     alu      fw     p  r  m  nw ce en      flags
    step("al_fw11",     1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b0100);
    step("eq_pass",     1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b0100);
    step("ne_fail",     1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b0100);
    step("set_1111",    1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b1111);
    step("part_nz",     1, 4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 1, 3'b000, 4'b0011);
    step("part_cv",     1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0, 1, 3'b000, 4'b0000);
    step("set_1001",    1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b1001);
    step("ge_1001",     1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b1001);
    step("gt_1001",     1, 4'b1100, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b1001);
    step("lt_1001",     1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b1001);
    step("le_1001",     1, 4'b1101, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b1001);
    step("set_1000",    1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b1000);
    step("lt_1000",     1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b1000);
    step("le_1000",     1, 4'b1101, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b1000);
    step("set_0100",    1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b0100);
    step("le_0100",     1, 4'b1101, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b0100);
    step("gt_0100",     1, 4'b1100, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b0100);
    step("nv_gated",    1, 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 3'b000, 4'b0100);
    step("nowrite",     1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1, 1, 3'b000, 4'b0110);
    step("invalid",     0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 3'b000, 4'b0000);
    step("pc_mem",      1, 4'b1110, 4'b1111, 2'b00, 1, 0, 1, 0, 1, 3'b101, 4'b0110);
    step("clr_flags",   1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 3'b000, 4'b0000);
    step("eq_nobypass", 1, 4'b0000, 4'b0100, 2'b11, 0, 1, 0, 0, 0, 3'b000, 4'b0000);
    step("hi_fail",     1, 4'b1000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 3'b000, 4'b0000);
    step("set_c",       1, 4'b1110, 4'b1110, 2'b01, 0, 0, 0, 0, 1, 3'b000, 4'b0010);
    step("hi_pass",     1, 4'b1000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 3'b100, 4'b0010);
    step("ls_fail",     1, 4'b1001, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 3'b000, 4'b0010);
    step("cs_pass",     1, 4'b0010, 4'b0000, 2'b00, 0, 0, 1, 0, 1, 3'b001, 4'b0010);
    step("cc_fail",     1, 4'b0011, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 3'b000, 4'b0010);
    step("mi_fail",     1, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b0010);
    step("pl_pass",     1, 4'b0101, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b0010);
    step("vs_fail",     1, 4'b0110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 3'b000, 4'b0010);
    step("vc_pass",     1, 4'b0111, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 3'b010, 4'b0010);

    // mid-stream reset during a stream of AL stores
    step("ms_a",        1, 4'b1110, 4'b1010, 2'b11, 0, 0, 1, 0, 1, 3'b001, 4'b1010);
    step("ms_b",        1, 4'b1110, 4'b1010, 2'b11, 0, 0, 1, 0, 1, 3'b001, 4'b1010);
    @(posedge clk); #2;
    check("ms_memwrite_before", {6'd0, mem_write}, 7'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("ms_memwrite_async", {5'd0, out_valid, mem_write}, 7'd0);
    check("ms_flags_reset", {3'd0, flags}, 7'd0);
    #5;
    reset_n = 1'b1;
    issue("ms_resume",  1, 4'b1110, 4'b1010, 2'b11, 0, 0, 1, 0, 1, 3'b001, 4'b1010);

    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size() > 7'd0 ? 7'd1 : 7'd0, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
